// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with a full-depth occupancy count, programmable almost-full
// and almost-empty flags, a registered or first-word-fall-through read port,
// and sticky overflow/underflow flags.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_L    = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_L    = AEMPTY_THRESH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_w;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  empty_w, full_w, rd_acc, wr_acc;

    // The extra pointer bit lets the difference reach DEPTH, so every slot is usable.
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (level_w == '0);
    assign full_w  = (level_w == DEPTH_L);

    always_comb begin
        rd_acc   = rd_en && !empty_w;
        wr_acc   = wr_en && (!full_w || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        // A fresh error in the same cycle as clr_err wins.
        ovf_d = (ovf_q && !clr_err) || (wr_en && !wr_acc);
        unf_d = (unf_q && !clr_err) || (rd_en && !rd_acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = rst ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            assign rd_valid = !empty_w;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (level_w >= AF_L);
    assign almost_empty = (level_w <= AE_L);
    assign level        = level_w;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a registered-read instance driven through a queue
// scoreboard and vector table, plus an FWFT instance exercised by hand.
module tb_sync_fifo_flex;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en0 = 0, rd_en0 = 0, clr_err0 = 0;
    logic [7:0] wr_data0 = 0, rd_data0;
    logic       rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [4:0] level0;

    logic       wr_en1 = 0, rd_en1 = 0, clr_err1 = 0;
    logic [7:0] wr_data1 = 0, rd_data1;
    logic       rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] level1;

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .level(level0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err0));

    sync_fifo_flex #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .level(level1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err1));

    int         nvec = 0, nerr = 0;
    logic [7:0] sb[$];
    int         mcnt = 0;
    bit         movf = 0, munf = 0;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        int         lvl;
        logic       ovf;
        logic       unf;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock on dut0; the queue model predicts acceptance, flags and read data.
    task automatic step0(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit racc, wacc;
        racc = r && (mcnt != 0);
        wacc = w && ((mcnt != 16) || racc);
        wr_en0 = w; wr_data0 = d; rd_en0 = r; clr_err0 = c;
        if (wacc) sb.push_back(d);
        @(posedge clk);
        #1;
        wr_en0 = 0; rd_en0 = 0; clr_err0 = 0;
        mcnt = mcnt + int'(wacc) - int'(racc);
        movf = (movf && !c) || (w && !wacc);
        munf = (munf && !c) || (r && !racc);
        chk("level", level0, mcnt);
        chk("full", full0, mcnt == 16);
        chk("empty", empty0, mcnt == 0);
        chk("almost_full", af0, mcnt >= 14);
        chk("almost_empty", ae0, mcnt <= 2);
        chk("overflow", ovf0, movf);
        chk("underflow", unf0, munf);
        chk("rd_valid", rd_valid0, racc);
        if (rd_valid0) begin
            if (sb.size() == 0) chk("scoreboard_underrun", 1, 0);
            else chk("rd_data", rd_data0, sb.pop_front());
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h22, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 8'h33, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 8'h44, 1'b0, 1'b0, 3, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_rd_data", rd_data0, 0);
        chk("rst_rd_valid", rd_valid0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_unf", unf0, 0);
        chk("rst_fwft_valid", rd_valid1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Error-flag corners: empty read, write+read on empty, clear vs new error.
        for (int i = 0; i < 10; i++) begin
            step0(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
            chk("tbl_level", level0, tbl[i].lvl);
            chk("tbl_ovf", ovf0, tbl[i].ovf);
            chk("tbl_unf", unf0, tbl[i].unf);
        end
        repeat (2) step0(0, 0, 1, 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) step0(1, 8'(i), 0, 0);
        chk("fill_full", full0, 1);
        step0(1, 8'hAA, 0, 0);
        chk("ovf_set", ovf0, 1);
        chk("ovf_level", level0, 16);

        // Drain in order, then one rejected read.
        for (int i = 0; i < 16; i++) step0(0, 0, 1, 0);
        chk("drain_data_last", rd_data0, 8'h0F);
        step0(0, 0, 1, 1);
        chk("unf_set", unf0, 1);
        chk("unf_no_valid", rd_valid0, 0);
        step0(0, 0, 0, 1);

        // Simultaneous write and read while full.
        for (int i = 0; i < 16; i++) step0(1, 8'h20 + 8'(i), 0, 0);
        step0(1, 8'h55, 1, 0);
        chk("fullrw_level", level0, 16);
        chk("fullrw_ovf", ovf0, 0);
        chk("fullrw_old", rd_data0, 8'h20);
        for (int i = 0; i < 16; i++) step0(0, 0, 1, 0);
        chk("fullrw_last", rd_data0, 8'h55);

        // Pointer wrap at a steady level of 3.
        for (int i = 0; i < 3; i++) step0(1, 8'h80 + 8'(i), 0, 0);
        for (int i = 3; i < 43; i++) begin
            step0(1, 8'h80 + 8'(i), 1, 0);
            chk("wrap_level", level0, 3);
        end
        repeat (3) step0(0, 0, 1, 0);

        // Reset mid-stream at level 7 with both sticky flags set and a read in flight.
        step0(0, 0, 1, 0);
        for (int i = 0; i < 17; i++) step0(1, 8'h40 + 8'(i), 0, 0);
        for (int i = 0; i < 9; i++) step0(0, 0, 1, 0);
        chk("pre_rst_level", level0, 7);
        rst = 1'b1;
        #1;
        chk("mid_rst_level", level0, 0);
        chk("mid_rst_empty", empty0, 1);
        chk("mid_rst_ovf", ovf0, 0);
        chk("mid_rst_unf", unf0, 0);
        chk("mid_rst_valid", rd_valid0, 0);
        sb.delete();
        mcnt = 0; movf = 0; munf = 0;
        @(negedge clk);
        rst = 1'b0;
        step0(1, 8'h99, 0, 0);
        step0(0, 0, 1, 0);
        chk("post_rst_data", rd_data0, 8'h99);

        // FWFT instance.
        @(negedge clk);
        chk("fwft_idle_valid", rd_valid1, 0);
        wr_en1 = 1; wr_data1 = 8'h3C;
        @(posedge clk); #1; wr_en1 = 0;
        chk("fwft_valid", rd_valid1, 1);
        chk("fwft_data", rd_data1, 8'h3C);
        rd_en1 = 1;
        @(posedge clk); #1; rd_en1 = 0;
        chk("fwft_pop_empty", empty1, 1);
        chk("fwft_pop_valid", rd_valid1, 0);
        wr_en1 = 1; wr_data1 = 8'h5A; rd_en1 = 1;
        @(posedge clk); #1; wr_en1 = 0; rd_en1 = 0;
        chk("fwft_wr_rd_empty_unf", unf1, 1);
        chk("fwft_wr_rd_empty_data", rd_data1, 8'h5A);
        chk("fwft_wr_rd_empty_level", level1, 1);
        wr_en1 = 1; wr_data1 = 8'h6B;
        @(posedge clk); #1; wr_en1 = 0;
        chk("fwft_head_held", rd_data1, 8'h5A);
        chk("fwft_level2", level1, 2);
        rd_en1 = 1;
        @(posedge clk); #1; rd_en1 = 0;
        chk("fwft_second", rd_data1, 8'h6B);
        chk("fwft_second_valid", rd_valid1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO; successor to the team's dual-clock FIFO for blocks that live in one clock domain.
- Adds a true full-depth count, a fill-level output, programmable almost-full/almost-empty flags, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer datapath in the same domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries, all usable.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2, almost_full asserts when level >= this value; legal range 1..DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserts when level <= this value; legal range 0..DEPTH-1.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data qualifier.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst is high, every output is held at its reset value.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level = 0.
  - empty = 1, full = 0, almost_empty = 1 (AEMPTY_THRESH >= 0), almost_full = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
- Pointers:
  - Binary, ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits address memory; wrap-around is natural modulo 2**(ADDR_WIDTH+1).
  - level = wr_ptr - rd_ptr, computed at ADDR_WIDTH+1 bits.
  - All flags are derived from the registered pointers and level.
- Read acceptance: rd_acc = rd_en && !empty.
- Write acceptance: wr_acc = wr_en && (!full || rd_acc). A write into a full FIFO is accepted in the same cycle as an accepted read. The read returns the old word; no data corruption.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr increments.
- Accepted read: rd_ptr increments.
- Level update: +1 on write only, -1 on read only, unchanged on both.
- FWFT=0 (registered read):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid = 1 in the following cycle. rd_valid is a one-cycle pulse per accepted read.
  - rd_data holds its last value otherwise.
  - Read latency is 1 clk.
- FWFT=1:
  - rd_data = mem[rd_ptr] and rd_valid = !empty, both combinational from registered state.
  - rd_en pops the presented word.
  - A write into an empty FIFO makes the word visible the cycle after the write edge.
- Simultaneous write and read while empty: the write is accepted, the read is rejected, and underflow is set. In FWFT mode the new word appears next cycle.
- overflow sets on wr_en && !wr_acc.
- underflow sets on rd_en && !rd_acc.
- Both error flags stay set until clr_err. If clr_err and a new error occur in the same cycle, the flag stays set.
- The thresholds are compile-time constants. The flags update in the same cycle as level.
- A reset asserted mid-operation discards all contents and in-flight reads immediately. A pending rd_valid pulse is suppressed.

Test Plan:
- Reset, then write 16 words 0x00..0x0F (DEPTH=16, FWFT=0) -> full=1, level=16, almost_full first asserts when level reaches 14, overflow stays 0. A 17th write (0xAA) is rejected and sets overflow=1, and the contents are unchanged.
- Read 16 words from the full FIFO, FWFT=0 -> rd_valid pulses one cycle after each rd_en with data 0x00..0x0F in order. empty=1 after the last read. An extra rd_en sets underflow=1 and gives no rd_valid.
- Full FIFO with wr_en and rd_en together carrying 0x55 -> both accepted, level stays 16, no overflow. The read returns the oldest word and 0x55 is later read last.
- FWFT=1: write 0x3C into an empty FIFO -> next cycle rd_valid=1 and rd_data=0x3C without rd_en. Pulsing rd_en once gives empty=1 and rd_valid=0 the following cycle.
- Pointer wrap: run 40 write/read pairs with incrementing data at level 3 -> data order is preserved across wrap and level stays 3 throughout.
- Assert rst mid-stream at level 7 with sticky flags set -> level=0, empty=1, overflow=0, underflow=0 immediately. A subsequent write/read of 0x99 returns 0x99.
